// File: rtl/divider_32bit_pkg.sv
// Shared constants and state encoding for the multi-cycle restoring divider.
package divider_32bit_pkg;

   localparam int unsigned DIV_W = 32;
   localparam int unsigned CNT_W = 5;

   localparam logic [CNT_W-1:0] CNT_LAST     = 5'd31;
   localparam logic [DIV_W-1:0] DBZ_QUOTIENT = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/adder_1bit.sv
// Single-bit full adder cell shared by the datapath's ripple arithmetic.
module adder_1bit (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_sum,
   output logic o_cout
);

   logic w_p;

   assign w_p    = i_a ^ i_b;
   assign o_sum  = w_p ^ i_cin;
   assign o_cout = (i_a & i_b) | (i_cin & w_p);

endmodule

// File: rtl/subtractor_32bit.sv
// Ripple subtractor: out = input1 - input2 as input1 + ~input2 + 1.
// borrow_n is the final carry-out, high when input1 >= input2.
module subtractor_32bit
   import divider_32bit_pkg::*;
(
   input  logic [DIV_W-1:0] input1,
   input  logic [DIV_W-1:0] input2,
   output logic [DIV_W-1:0] out,
   output logic             borrow_n
);

   logic [DIV_W:0] w_carry;

   assign w_carry[0] = 1'b1;

   for (genvar g = 0; g < DIV_W; g++) begin : g_cell
      adder_1bit u_add (
         .i_a    (input1[g]),
         .i_b    (~input2[g]),
         .i_cin  (w_carry[g]),
         .o_sum  (out[g]),
         .o_cout (w_carry[g+1])
      );
   end

   assign borrow_n = w_carry[DIV_W];

endmodule

// File: rtl/divider_32bit.sv
// Unsigned 32-bit restoring divider: one shift-and-subtract step per clock,
// start/busy/done handshake, divide-by-zero short-circuits straight to DONE.
module divider_32bit
   import divider_32bit_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [DIV_W-1:0] dividend,
   input  logic [DIV_W-1:0] divisor,
   output logic [DIV_W-1:0] quotient,
   output logic [DIV_W-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   state_t             r_state;
   state_t             w_state_next;
   logic [CNT_W-1:0]   r_count;
   logic [DIV_W-1:0]   r_q;
   logic [DIV_W-1:0]   r_r;
   logic [DIV_W-1:0]   r_divisor;
   logic               r_dbz;

   logic               w_accept;
   logic               w_div_zero;
   logic [DIV_W-1:0]   w_s;
   logic               w_h;
   logic [DIV_W-1:0]   w_d;
   logic               w_borrow_n;

   assign w_accept   = start && (r_state != ST_RUN);
   assign w_div_zero = (divisor == '0);

   // Shifted partial remainder; the bit shifted out of R must force a subtract.
   assign w_s = {r_r[DIV_W-2:0], r_q[DIV_W-1]};
   assign w_h = r_r[DIV_W-1];

   subtractor_32bit u_sub (
      .input1   (w_s),
      .input2   (r_divisor),
      .out      (w_d),
      .borrow_n (w_borrow_n)
   );

   // NOTE: the default assignment first keeps this block free of inferred latches.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (w_accept) w_state_next = w_div_zero ? ST_DONE : ST_RUN;
            else          w_state_next = ST_IDLE;
         end
         ST_RUN:  if (r_count == CNT_LAST) w_state_next = ST_DONE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_next;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_q       <= '0;
         r_r       <= '0;
         r_divisor <= '0;
         r_count   <= '0;
         r_dbz     <= 1'b0;
      end else if (w_accept) begin
         r_divisor <= divisor;
         r_count   <= '0;
         if (w_div_zero) begin
            r_q   <= DBZ_QUOTIENT;
            r_r   <= dividend;
            r_dbz <= 1'b1;
         end else begin
            r_q   <= dividend;
            r_r   <= '0;
            r_dbz <= 1'b0;
         end
      end else if (r_state == ST_RUN) begin
         r_count <= r_count + 1'b1;
         if (w_h || w_borrow_n) begin
            r_r <= w_d;
            r_q <= {r_q[DIV_W-2:0], 1'b1};
         end else begin
            r_r <= w_s;
            r_q <= {r_q[DIV_W-2:0], 1'b0};
         end
      end
   end

   assign quotient    = r_q;
   assign remainder   = r_r;
   assign div_by_zero = r_dbz;
   assign busy        = (r_state == ST_RUN);
   assign done        = (r_state == ST_DONE);

endmodule

// File: tb/tb_divider_32bit.sv
// Directed self-checking bench for divider_32bit: results, latency, handshake and reset abort.
module tb_divider_32bit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        busy;
   logic        done;
   logic        div_by_zero;

   int checks   = 0;
   int failures = 0;
   int overlap  = 0;

   always #5 clk = ~clk;

   divider_32bit dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   always @(negedge clk) if (busy && done) overlap++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [31:0] dd, input logic [31:0] dv);
      dividend = dd;
      divisor  = dv;
      start    = 1'b1;
   endtask

   // Counts edges from the accepting edge until done is seen; optionally
   // injects an ignored start with new operands at edge index inject_at.
   task automatic wait_done(input int inject_at, output int edges, output int busy_cycles);
      edges       = 0;
      busy_cycles = 0;
      do begin
         tick();
         edges++;
         if (busy) busy_cycles++;
         if (edges == inject_at) launch(32'd50, 32'd5);
         else                    start = 1'b0;
      end while (!done && edges < 40);
      if (!done) check("timeout_waiting_done", 32'(edges), 32'd33);
   endtask

   task automatic run_div(input string tag, input logic [31:0] dd, input logic [31:0] dv,
                          input logic [31:0] exp_q, input logic [31:0] exp_r,
                          input int exp_edges);
      int n, b;
      launch(dd, dv);
      wait_done(0, n, b);
      check({tag, "_q"}, quotient, exp_q);
      check({tag, "_r"}, remainder, exp_r);
      check({tag, "_latency"}, 32'(n), 32'(exp_edges));
      check({tag, "_dbz"}, 32'(div_by_zero), (dv == 32'd0) ? 32'd1 : 32'd0);
   endtask

   initial begin
      int n, b;
      reset    = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      tick();
      tick();
      check("reset_q", quotient, 32'd0);
      check("reset_r", remainder, 32'd0);
      check("reset_flags", {29'd0, busy, done, div_by_zero}, 32'd0);
      reset = 1'b0;
      tick();

      // Basic divide with latency and busy-width checks.
      launch(32'd100, 32'd7);
      wait_done(0, n, b);
      check("basic_q", quotient, 32'd14);
      check("basic_r", remainder, 32'd2);
      check("basic_latency", 32'(n), 32'd33);
      check("basic_busy_cycles", 32'(b), 32'd32);
      check("basic_dbz", 32'(div_by_zero), 32'd0);
      tick();
      check("done_single_pulse", 32'(done), 32'd0);
      check("held_q", quotient, 32'd14);
      check("held_r", remainder, 32'd2);

      run_div("max_by_one", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 33);
      tick();
      run_div("msb_by_max", 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);
      tick();
      run_div("carry_out", 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 33);
      tick();
      run_div("div_zero", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1);
      tick();
      run_div("after_zero", 32'd9, 32'd3, 32'd3, 32'd0, 33);
      tick();

      // Start during RUN is ignored; start in the done cycle is accepted.
      launch(32'd100, 32'd7);
      wait_done(5, n, b);
      check("ignore_start_q", quotient, 32'd14);
      check("ignore_start_r", remainder, 32'd2);
      check("ignore_start_latency", 32'(n), 32'd33);
      run_div("back_to_back", 32'd50, 32'd5, 32'd10, 32'd0, 33);
      tick();

      // Asynchronous reset mid-run aborts with no done pulse.
      launch(32'd100, 32'd7);
      tick();
      start = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      check("pre_reset_busy", 32'(busy), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("abort_q", quotient, 32'd0);
      check("abort_r", remainder, 32'd0);
      check("abort_flags", {29'd0, busy, done, div_by_zero}, 32'd0);
      n = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (i == 2) reset = 1'b0;
         if (done) n++;
      end
      check("abort_no_done", 32'(n), 32'd0);
      run_div("after_abort", 32'd100, 32'd7, 32'd14, 32'd2, 33);

      check("busy_done_overlap", 32'(overlap), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
